// File: rtl/pkt_rx_pkg.sv
// Shared types and constants for the 10G MAC receive drain.
package pkt_rx_pkg;

    localparam int unsigned PKT_RX_DEPTH = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = ST_IDLE,
        S_READ = ST_READ
    } pkt_rx_state_e;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
    } pkt_rx_word_t;

    // A mod of 0 on the eop word means all eight bytes are valid.
    function automatic logic [3:0] mod_to_bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
    endfunction

endpackage

// File: rtl/pkt_rx_fifo.sv
// Four-entry synchronous FIFO; head entry is read straight from storage registers.
module pkt_rx_fifo
    import pkt_rx_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  pkt_rx_word_t wr_word,
    input  logic         rd_en,
    output pkt_rx_word_t rd_word,
    output logic         rd_valid,
    output logic [2:0]   count
);

    pkt_rx_word_t mem [PKT_RX_DEPTH];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic         push;
    logic         pop;

    assign push     = wr_en && (count != 3'(PKT_RX_DEPTH));
    assign pop      = rd_en && (count != 3'd0);
    assign rd_word  = mem[rd_ptr];
    assign rd_valid = (count != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PKT_RX_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_word;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_rx_drain.sv
// Pulls whole frames from the MAC RX FIFO into a credit-managed buffer.
// Statistics counters and ports exist only when PKT_RX_STATS_EN is defined.
module pkt_rx_drain
    import pkt_rx_pkg::*;
#(
    parameter int unsigned CNT_W = 32
)
(
    input  logic             clk_156m25,
    input  logic             reset_156m25,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic             pkt_rx_err,
    input  logic [2:0]       pkt_rx_mod,
    output logic [63:0]      out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic [2:0]       out_mod,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PKT_RX_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_pkt_cnt,
    output logic [CNT_W-1:0] stat_err_cnt,
    output logic [CNT_W-1:0] stat_byte_cnt
`endif
);

    pkt_rx_state_e state;
    pkt_rx_state_e state_nxt;
    logic          ren_d1;
    logic [2:0]    fifo_count;
    logic          credit_ok;
    logic          last_word;
    pkt_rx_word_t  wr_word;
    pkt_rx_word_t  rd_word;

    assign last_word = pkt_rx_val && pkt_rx_eop;
    // Words already requested but not yet returned hold a credit too.
    assign credit_ok = ({1'b0, fifo_count} + {3'b000, ren_d1}) <= 4'(PKT_RX_DEPTH - 1);

    always_comb begin
        state_nxt  = state;
        pkt_rx_ren = 1'b0;
        case (state)
            S_IDLE: begin
                if (pkt_rx_avail) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                pkt_rx_ren = credit_ok && !last_word;
                if (last_word) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state  <= S_IDLE;
            ren_d1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            ren_d1 <= pkt_rx_ren;
        end
    end

    assign wr_word = {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod};

    pkt_rx_fifo u_fifo (
        .clk      (clk_156m25),
        .rst      (reset_156m25),
        .wr_en    (pkt_rx_val),
        .wr_word  (wr_word),
        .rd_en    (out_ready),
        .rd_word  (rd_word),
        .rd_valid (out_valid),
        .count    (fifo_count)
    );

    assign out_data = rd_word.data;
    assign out_sop  = rd_word.sop;
    assign out_eop  = rd_word.eop;
    assign out_err  = rd_word.err;
    assign out_mod  = rd_word.mod;

`ifdef PKT_RX_STATS_EN
    logic [3:0] word_bytes;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign word_bytes = pkt_rx_eop ? mod_to_bytes(pkt_rx_mod) : 4'd8;

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            stat_pkt_cnt  <= '0;
            stat_err_cnt  <= '0;
            stat_byte_cnt <= '0;
        end else if (stat_clr) begin
            stat_pkt_cnt  <= '0;
            stat_err_cnt  <= '0;
            stat_byte_cnt <= '0;
        end else if (pkt_rx_val) begin
            stat_byte_cnt <= sat_add(stat_byte_cnt, word_bytes);
            if (pkt_rx_eop) begin
                stat_pkt_cnt <= sat_add(stat_pkt_cnt, 4'd1);
                if (pkt_rx_err) begin
                    stat_err_cnt <= sat_add(stat_err_cnt, 4'd1);
                end
            end
        end
    end
`endif

endmodule

// File: doc/pkt_rx_drain.md
# pkt_rx_drain

Receive-side consumer for the 10G MAC packet interface, on the 156.25 MHz domain. It watches `pkt_rx_avail` and drives `pkt_rx_ren` to pull one whole frame at a time out of the MAC RX FIFO. Received words go into a small credit-managed buffer and are re-presented as a valid/ready stream to the downstream packet consumer. Optional statistics counters track packets, errored packets and bytes.

## Interface
- `CNT_W`, default 32: width of each statistics counter.
- `DEPTH`, fixed localparam 4: buffer entries.

Ports:
- `clk_156m25`  in  1  — core clock.
- `reset_156m25`  in  1  — asynchronous, active-high reset.
- `pkt_rx_avail`  in  1  — MAC holds at least one complete frame.
- `pkt_rx_ren`  out  1  — read enable to the MAC. Data is returned one cycle later.
- `pkt_rx_data`  in  64  — MAC word.
- `pkt_rx_val`  in  1  — word valid.
- `pkt_rx_sop`  in  1  — first word of a frame.
- `pkt_rx_eop`  in  1  — last word of a frame.
- `pkt_rx_err`  in  1  — frame error, meaningful on the eop word.
- `pkt_rx_mod`  in  3  — valid bytes in the eop word; 0 means 8.
- `out_data`  out  64  — buffered word.
- `out_sop`  out  1  — first word of a frame.
- `out_eop`  out  1  — last word of a frame.
- `out_err`  out  1  — frame error.
- `out_mod`  out  3  — passthrough of `pkt_rx_mod`.
- `out_valid`  out  1  — output word valid.
- `out_ready`  in  1  — downstream accepts.
- `stat_clr`  in  1  — synchronous counter clear. Present only when `PKT_RX_STATS_EN` is defined.
- `stat_pkt_cnt`, `stat_err_cnt`, `stat_byte_cnt`  out  `CNT_W`  — counters. Present only when `PKT_RX_STATS_EN` is defined.

## Operation
FSM states:
- IDLE: `pkt_rx_ren` = 0. Moves to READ on the clock edge where `pkt_rx_avail` = 1.
- READ: `pkt_rx_ren` = credit_ok && !(`pkt_rx_val` && `pkt_rx_eop`), combinational.
  - credit_ok = (fifo_count + ren_d1 ≤ DEPTH−1), where ren_d1 is `pkt_rx_ren` registered.
  - This guarantees no overflow even with zero pops.
  - When `pkt_rx_val` && `pkt_rx_eop`: return to IDLE. `pkt_rx_ren` is already low in that cycle, so a following frame is never read early.

Buffer and output:
- Buffer write on `pkt_rx_val` only. The MAC may return val = 0 after a ren; that cycle simply writes nothing.
- Buffer word: {data, sop, eop, err, mod}, 70 bits.
- Output transfer when `out_valid` && `out_ready`.
- All `out_*` fields are held stable while `out_valid` && !`out_ready`.
- Words are delivered in order and never dropped or duplicated.
- Simultaneous push and pop leaves fifo_count unchanged.
- A `pkt_rx_val` arriving in IDLE is a protocol violation. The word is still written; behaviour is otherwise undefined.

Reset:
- Reset asserted mid-frame clears the FSM, buffer and counters immediately.
- The MAC must be reset together with this block; no resynchronisation to sop is performed.

## Timing
- Reset values: `pkt_rx_ren` = 0, `out_valid` = 0, `out_data` = 0, `out_sop`/`out_eop`/`out_err` = 0, `out_mod` = 0, all counters 0.
- Latency:
  - `pkt_rx_avail` sampled high at edge t.
  - `pkt_rx_ren` high in cycle t+1.
  - Word arrives in cycle t+2.
  - `out_valid` high in cycle t+3 (registered buffer output).
- Gap between frames: at least one cycle with `pkt_rx_ren` = 0, which is the IDLE cycle.
- Sustained throughput is one word per cycle while `out_ready` = 1.

## Configuration
- `PKT_RX_STATS_EN` defined: the stats ports and counters exist.
  - Counters update on the buffer write of each eop word.
  - `stat_pkt_cnt` +1 per frame.
  - `stat_err_cnt` +1 if err is set on that word.
  - `stat_byte_cnt` += 8 per non-eop word, and (mod == 0 ? 8 : mod) on the eop word.
  - Counters saturate at all-ones.
  - `stat_clr` wins over a simultaneous increment.
- `PKT_RX_STATS_EN` undefined: the ports and logic are absent. Datapath behaviour is identical.

## Structure
- Package `pkt_rx_pkg`:
  - FSM state enum.
  - `PKT_RX_DEPTH` = 4.
  - Buffer word struct.
  - Function `mod_to_bytes`.
- Sub-module `pkt_rx_fifo`: 4-entry synchronous FIFO with registered output, count output, async active-high reset.

## Test plan
- Single-word frame, mod = 5, `out_ready` = 1 → `pkt_rx_ren` high for exactly 1 cycle. Output `out_sop` = `out_eop` = 1, `out_mod` = 5 at avail+3. `stat_byte_cnt` = 5.
- 6-word frame, `out_ready` = 0 → `pkt_rx_ren` stops after 4 words, no overflow. Releasing `out_ready` delivers all 6 words in order. `stat_byte_cnt` = 48 with mod = 0.
- Frame with err = 1 on eop → `out_err` = 1 on the eop word only. `stat_err_cnt` = 1, `stat_pkt_cnt` = 1.
- Two back-to-back frames with `pkt_rx_avail` held high → `pkt_rx_ren` low in the eop cycle and the following cycle. The second sop does not merge into the first frame.
- Reset asserted mid-frame → `out_valid` and `pkt_rx_ren` go to 0 without waiting for a clock edge. The buffer is empty after release.
- `CNT_W` = 4, 17 frames → `stat_pkt_cnt` = 15, saturated. `stat_clr` coincident with an eop → counter = 0.
